// File: rtl/ram_master_4x8_if.sv
// Host command/response and RAM bus signals of the RAM initiator.
// The master modport is the initiator's view; slave is the host/RAM side.
interface ram_master_4x8_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [ADDR_W-1:0] req_len;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_last;
  logic [DATA_W-1:0] resp_rdata;
  logic              wr_done;
  logic              busy;
  logic              mem_rw;
  logic [ADDR_W-1:0] mem_endereco;
  logic [DATA_W-1:0] mem_data_in;
  logic [DATA_W-1:0] mem_data_out;

  modport master (
    input  req_valid, req_write, req_addr, req_len, req_wdata, mem_data_out,
    output req_ready, resp_valid, resp_last, resp_rdata, wr_done, busy,
           mem_rw, mem_endereco, mem_data_in
  );

  modport slave (
    output req_valid, req_write, req_addr, req_len, req_wdata, mem_data_out,
    input  req_ready, resp_valid, resp_last, resp_rdata, wr_done, busy,
           mem_rw, mem_endereco, mem_data_in
  );
endinterface

// File: rtl/ram_master_4x8.sv
// Burst read/write initiator for a small clocked RAM; one command at a time, no queueing.
// Writes take len+1 bus cycles plus a DONE cycle; reads return one strobe per beat, no backpressure.
module ram_master_4x8 #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 2,
  parameter int READ_LAT = 1
) (
  input  logic                  clock,
  input  logic                  clear,
  ram_master_4x8_if.master      bus
);

  localparam int LAT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

  state_t            state, state_nxt;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [ADDR_W-1:0] cmd_len;
  logic [DATA_W-1:0] cmd_wdata;
  logic [ADDR_W-1:0] beat;
  logic [LAT_W-1:0]  lat_cnt;
  logic              accept;
  logic              capture;
  logic              last_beat;
  logic              lat_done;

  always_ff @(posedge clock) begin
    if (!clear) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt        = state;
    accept           = 1'b0;
    capture          = 1'b0;
    last_beat        = (beat == cmd_len);
    lat_done         = (lat_cnt == LAT_W'(READ_LAT - 1));
    bus.req_ready    = 1'b0;
    bus.busy         = 1'b1;
    bus.wr_done      = 1'b0;
    bus.mem_rw       = 1'b0;
    bus.mem_endereco = '0;
    bus.mem_data_in  = '0;
    case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        bus.busy      = 1'b0;
        if (bus.req_valid) begin
          accept    = 1'b1;
          state_nxt = bus.req_write ? WRITE : READ;
        end
      end
      WRITE: begin
        bus.mem_rw       = 1'b1;
        bus.mem_endereco = cmd_addr + beat;
        bus.mem_data_in  = cmd_wdata + DATA_W'(beat);
        if (last_beat) state_nxt = DONE;
      end
      READ: begin
        // Address stays on the bus for READ_LAT cycles; data is taken on the last one.
        bus.mem_endereco = cmd_addr + beat;
        if (lat_done) begin
          capture = 1'b1;
          if (last_beat) state_nxt = IDLE;
        end
      end
      DONE: begin
        bus.wr_done = 1'b1;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!clear) begin
      cmd_write      <= 1'b0;
      cmd_addr       <= '0;
      cmd_len        <= '0;
      cmd_wdata      <= '0;
      beat           <= '0;
      lat_cnt        <= '0;
      bus.resp_valid <= 1'b0;
      bus.resp_last  <= 1'b0;
      bus.resp_rdata <= '0;
    end else begin
      bus.resp_valid <= 1'b0;
      bus.resp_last  <= 1'b0;
      if (accept) begin
        cmd_write <= bus.req_write;
        cmd_addr  <= bus.req_addr;
        cmd_len   <= bus.req_len;
        cmd_wdata <= bus.req_wdata;
        beat      <= '0;
        lat_cnt   <= '0;
      end else if (state == WRITE && !last_beat) begin
        beat <= beat + 1'b1;
      end else if (state == READ) begin
        if (capture) begin
          bus.resp_rdata <= bus.mem_data_out;
          bus.resp_valid <= 1'b1;
          bus.resp_last  <= last_beat;
          beat           <= beat + 1'b1;
          lat_cnt        <= '0;
        end else begin
          lat_cnt <= lat_cnt + 1'b1;
        end
      end
    end
  end

  // cmd_write is kept for visibility of the accepted command; the state already encodes it.
  logic unused_cmd_write;
  assign unused_cmd_write = cmd_write;

endmodule

// File: tb/tb_ram_master_4x8.sv
// Bench for ram_master_4x8: behavioural 4x8 RAM on the bus, read data checked through a scoreboard queue.
module tb_ram_master_4x8;
  logic clock;
  logic clear;
  int   n_checks;
  int   n_errors;

  ram_master_4x8_if #(.DATA_W(8), .ADDR_W(2)) bus ();

  ram_master_4x8 #(.DATA_W(8), .ADDR_W(2), .READ_LAT(1)) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus.master)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [7:0] ram [4];
  logic       ram_init;
  always @(posedge clock) begin
    if (ram_init) begin
      for (int k = 0; k < 4; k++) ram[k] <= 8'h00;
    end else if (bus.mem_rw === 1'b1) begin
      ram[bus.mem_endereco] <= bus.mem_data_in;
    end
  end
  assign bus.mem_data_out = ram[bus.mem_endereco];

  logic [7:0] exp_mem [4];
  logic [7:0] exp_q   [$];
  logic       last_q  [$];

  task automatic issue(input logic wr, input logic [1:0] a, input logic [1:0] len,
                       input logic [7:0] wd, input string nm);
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = a;
    bus.req_len   = len;
    bus.req_wdata = wd;
    n_checks++;
    if (bus.req_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL %s accept_ready: got %0b want 1", nm, bus.req_ready);
    end
    @(posedge clock);
    @(negedge clock);
    bus.req_valid = 1'b0;
  endtask

  task automatic test_write(input logic [1:0] a, input logic [1:0] len,
                            input logic [7:0] wd, input string nm);
    int n;
    logic [1:0] ea;
    logic [7:0] ed;
    n = int'(len) + 1;
    issue(1'b1, a, len, wd, nm);
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clock);
      ea = 2'(int'(a) + i);
      ed = 8'(int'(wd) + i);
      n_checks++;
      if (bus.mem_rw !== 1'b1 || bus.mem_endereco !== ea || bus.mem_data_in !== ed ||
          bus.req_ready !== 1'b0) begin
        n_errors++;
        $display("FAIL %s beat%0d: got rw=%0b addr=%0d data=%h rdy=%0b want rw=1 addr=%0d data=%h rdy=0",
                 nm, i, bus.mem_rw, bus.mem_endereco, bus.mem_data_in, bus.req_ready, ea, ed);
      end
      exp_mem[ea] = ed;
    end
    @(negedge clock);
    n_checks++;
    if (bus.wr_done !== 1'b1 || bus.mem_rw !== 1'b0 || bus.busy !== 1'b1) begin
      n_errors++;
      $display("FAIL %s done_cycle: got wr_done=%0b rw=%0b busy=%0b want 1 0 1",
               nm, bus.wr_done, bus.mem_rw, bus.busy);
    end
    @(negedge clock);
    n_checks++;
    if (bus.wr_done !== 1'b0 || bus.req_ready !== 1'b1 || bus.mem_endereco !== 2'd0 ||
        bus.mem_data_in !== 8'h00) begin
      n_errors++;
      $display("FAIL %s back_idle: got wr_done=%0b rdy=%0b addr=%0d data=%h want 0 1 0 00",
               nm, bus.wr_done, bus.req_ready, bus.mem_endereco, bus.mem_data_in);
    end
  endtask

  task automatic test_read(input logic [1:0] a, input logic [1:0] len, input string nm);
    int n;
    logic [7:0] ed;
    logic el;
    logic want_vld;
    n = int'(len) + 1;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(exp_mem[2'(int'(a) + i)]);
      last_q.push_back(i == n - 1);
    end
    issue(1'b0, a, len, 8'h00, nm);
    for (int c = 1; c <= n + 2; c++) begin
      if (c > 1) @(negedge clock);
      want_vld = (c >= 2 && c <= n + 1);
      n_checks++;
      if (bus.resp_valid !== want_vld || bus.req_ready !== (c >= n + 1) || bus.mem_rw !== 1'b0) begin
        n_errors++;
        $display("FAIL %s cycle%0d: got vld=%0b rdy=%0b rw=%0b want vld=%0b rdy=%0b rw=0",
                 nm, c, bus.resp_valid, bus.req_ready, bus.mem_rw, want_vld, (c >= n + 1));
      end
      if (bus.resp_valid === 1'b1 && exp_q.size() > 0) begin
        ed = exp_q.pop_front();
        el = last_q.pop_front();
        n_checks++;
        if (bus.resp_rdata !== ed || bus.resp_last !== el) begin
          n_errors++;
          $display("FAIL %s resp_cycle%0d: got data=%h last=%0b want data=%h last=%0b",
                   nm, c, bus.resp_rdata, bus.resp_last, ed, el);
        end
      end
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL %s missing_resp: got %0d outstanding want 0", nm, exp_q.size());
    end
    exp_q.delete();
    last_q.delete();
  endtask

  task automatic test_reset();
    clear         = 1'b0;
    ram_init      = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = 2'd1;
    bus.req_len   = 2'd3;
    bus.req_wdata = 8'h77;
    @(posedge clock);
    @(negedge clock);
    ram_init = 1'b0;
    n_checks++;
    if (bus.mem_rw !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_edge1 mem_rw: got %0b want 0", bus.mem_rw);
    end
    @(posedge clock);
    @(negedge clock);
    n_checks++;
    if (bus.resp_valid !== 1'b0 || bus.resp_last !== 1'b0 || bus.resp_rdata !== 8'h00 ||
        bus.wr_done !== 1'b0 || bus.busy !== 1'b0 || bus.mem_rw !== 1'b0 ||
        bus.mem_endereco !== 2'd0 || bus.mem_data_in !== 8'h00 || bus.req_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_outputs: got vld=%0b last=%0b rdata=%h done=%0b busy=%0b rw=%0b addr=%0d din=%h rdy=%0b want 0 0 00 0 0 0 0 00 1",
               bus.resp_valid, bus.resp_last, bus.resp_rdata, bus.wr_done, bus.busy,
               bus.mem_rw, bus.mem_endereco, bus.mem_data_in, bus.req_ready);
    end
    n_checks++;
    if (ram[1] !== 8'h00 || ram[2] !== 8'h00) begin
      n_errors++;
      $display("FAIL reset_no_write: got ram1=%h ram2=%h want 00 00", ram[1], ram[2]);
    end
    bus.req_valid = 1'b0;
    clear         = 1'b1;
    for (int k = 0; k < 4; k++) exp_mem[k] = 8'h00;
    @(negedge clock);
  endtask

  task automatic test_single();
    test_write(2'd2, 2'd0, 8'hA5, "single_wr");
    test_read(2'd2, 2'd0, "single_rd");
  endtask

  task automatic test_wrap();
    test_write(2'd3, 2'd3, 8'hFE, "wrap_wr");
    n_checks++;
    if (ram[3] !== 8'hFE || ram[0] !== 8'hFF || ram[1] !== 8'h00 || ram[2] !== 8'h01) begin
      n_errors++;
      $display("FAIL wrap_ram: got %h %h %h %h want FF 00 01 FE (addr0..3)",
               ram[0], ram[1], ram[2], ram[3]);
    end
    test_read(2'd1, 2'd3, "wrap_rd");
  endtask

  task automatic test_hold_valid();
    int wr_cnt;
    int done_cnt;
    wr_cnt   = 0;
    done_cnt = 0;
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = 2'd0;
    bus.req_len   = 2'd3;
    bus.req_wdata = 8'h40;
    @(posedge clock);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clock);
      if (bus.mem_rw === 1'b1) wr_cnt++;
      if (bus.wr_done === 1'b1) begin
        done_cnt++;
        bus.req_valid = 1'b0;
      end
    end
    bus.req_valid = 1'b0;
    n_checks++;
    if (wr_cnt != 4 || done_cnt != 1) begin
      n_errors++;
      $display("FAIL hold_valid_count: got writes=%0d done=%0d want 4 1", wr_cnt, done_cnt);
    end
    n_checks++;
    if (ram[0] !== 8'h40 || ram[1] !== 8'h41 || ram[2] !== 8'h42 || ram[3] !== 8'h43) begin
      n_errors++;
      $display("FAIL hold_valid_ram: got %h %h %h %h want 40 41 42 43", ram[0], ram[1], ram[2], ram[3]);
    end
    for (int k = 0; k < 4; k++) exp_mem[k] = 8'(8'h40 + k);
  endtask

  task automatic test_reset_mid();
    int done_cnt;
    done_cnt = 0;
    issue(1'b1, 2'd0, 2'd3, 8'h10, "abort");
    @(negedge clock);
    clear = 1'b0;
    @(negedge clock);
    n_checks++;
    if (bus.mem_rw !== 1'b0 || bus.req_ready !== 1'b1 || bus.wr_done !== 1'b0) begin
      n_errors++;
      $display("FAIL abort_after_clear: got rw=%0b rdy=%0b done=%0b want 0 1 0",
               bus.mem_rw, bus.req_ready, bus.wr_done);
    end
    clear = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      if (bus.wr_done === 1'b1 || bus.resp_valid === 1'b1) done_cnt++;
    end
    n_checks++;
    if (done_cnt != 0) begin
      n_errors++;
      $display("FAIL abort_no_done: got %0d strobes want 0", done_cnt);
    end
    n_checks++;
    if (ram[0] !== 8'h10 || ram[1] !== 8'h11 || ram[2] !== 8'h42 || ram[3] !== 8'h43) begin
      n_errors++;
      $display("FAIL abort_ram: got %h %h %h %h want 10 11 42 43", ram[0], ram[1], ram[2], ram[3]);
    end
    exp_mem[0] = 8'h10;
    exp_mem[1] = 8'h11;
  endtask

  task automatic test_back_to_back();
    test_read(2'd0, 2'd3, "b2b_rd_full");
    test_write(2'd1, 2'd1, 8'hFF, "b2b_wr");
    test_read(2'd1, 2'd1, "b2b_rd");
  endtask

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = 2'd0;
    bus.req_len   = 2'd0;
    bus.req_wdata = 8'h00;
    test_reset();
    test_single();
    test_wrap();
    test_hold_valid();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end
endmodule
